// File: rtl/ex_mem_flag_reg.sv
// EX/MEM pipeline register with NZCV flag capture and a combinational zero detect for CBZ.
// Optional FLAG_BYPASS_EN: flags_nzvc forwards newly computed flags during the accept cycle.
module ex_mem_flag_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_cmsb,
  input  logic [2:0]        alu_cntrl,
  input  logic              set_flags,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  output logic [3:0]        flags_nzvc,
  output logic              zero_now
);

  // Handshake: a transfer happens on a rising edge when valid && ready on that side.
  // Upstream may load whenever the slot is empty or draining this cycle, unless flushed.

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [REG_W-1:0]  out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              out_mem_read_q, out_mem_read_d;
  logic              out_mem_write_q, out_mem_write_d;
  logic [DATA_W-1:0] out_store_data_q, out_store_data_d;
  logic [3:0]        flags_q, flags_d;

  logic       accept;
  logic       op_arith;
  logic       op_logic;
  logic       flag_upd;
  logic [3:0] new_flags;

  always_comb begin
    in_ready = (!out_valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;
    zero_now = (alu_result == '0);

    op_arith = (alu_cntrl == 3'b010) || (alu_cntrl == 3'b011);
    op_logic = (alu_cntrl == 3'b000) || (alu_cntrl == 3'b100) ||
               (alu_cntrl == 3'b101) || (alu_cntrl == 3'b110);
    // Reserved encodings never touch the flags, even when set_flags is asserted.
    flag_upd = accept && set_flags && (op_arith || op_logic);

    new_flags = {alu_result[DATA_W-1], zero_now, 1'b0, 1'b0};
    if (op_arith) begin
      new_flags[1] = alu_cout;
      new_flags[0] = alu_cout ^ alu_cmsb;
    end

    out_valid_d      = out_valid_q && !out_ready;
    out_result_d     = out_result_q;
    out_rd_d         = out_rd_q;
    out_reg_write_d  = out_reg_write_q;
    out_mem_read_d   = out_mem_read_q;
    out_mem_write_d  = out_mem_write_q;
    out_store_data_d = out_store_data_q;
    flags_d          = flags_q;

    if (accept) begin
      out_valid_d      = 1'b1;
      out_result_d     = alu_result;
      out_rd_d         = rd;
      out_reg_write_d  = reg_write;
      out_mem_read_d   = mem_read;
      out_mem_write_d  = mem_write;
      out_store_data_d = store_data;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end
    if (flag_upd) begin
      flags_d = new_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      out_mem_read_q   <= 1'b0;
      out_mem_write_q  <= 1'b0;
      out_store_data_q <= '0;
      flags_q          <= 4'b0000;
    end else begin
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_rd_q         <= out_rd_d;
      out_reg_write_q  <= out_reg_write_d;
      out_mem_read_q   <= out_mem_read_d;
      out_mem_write_q  <= out_mem_write_d;
      out_store_data_q <= out_store_data_d;
      flags_q          <= flags_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_read   = out_mem_read_q;
  assign out_mem_write  = out_mem_write_q;
  assign out_store_data = out_store_data_q;

`ifdef FLAG_BYPASS_EN
  assign flags_nzvc = flag_upd ? new_flags : flags_q;
`else
  assign flags_nzvc = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// Directed bench for ex_mem_flag_reg: reset, flag rules, back-pressure, flush, bypass timing.
module tb_ex_mem_flag_reg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              alu_cmsb;
  logic [2:0]        alu_cntrl;
  logic              set_flags;
  logic [REG_W-1:0]  rd;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] store_data;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic [DATA_W-1:0] out_store_data;
  logic [3:0]        flags_nzvc;
  logic              zero_now;

  int total;
  int bad;

  ex_mem_flag_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_cmsb(alu_cmsb),
    .alu_cntrl(alu_cntrl), .set_flags(set_flags),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .store_data(store_data), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .flags_nzvc(flags_nzvc), .zero_now(zero_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [2:0] op,
                       input logic cout, input logic cmsb, input logic sf);
    in_valid   = v;
    alu_result = res;
    alu_cntrl  = op;
    alu_cout   = cout;
    alu_cmsb   = cmsb;
    set_flags  = sf;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    drive(1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    rd = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    store_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_flags", {60'b0, flags_nzvc}, 64'd0);
    check("rst_result", out_result, 64'd0);

    // add overflow: N=1 Z=0 C=0 V=1
    drive(1'b1, 64'h8000_0000_0000_0000, 3'b010, 1'b0, 1'b1, 1'b1);
    rd = 5'd5; reg_write = 1'b1; mem_write = 1'b1; store_data = 64'h1234;
    out_ready = 1'b1;
    #1;
    check("add_in_ready", {63'b0, in_ready}, 64'd1);
    check("add_zero_now", {63'b0, zero_now}, 64'd0);
    tick();
    check("add_valid", {63'b0, out_valid}, 64'd1);
    check("add_result", out_result, 64'h8000_0000_0000_0000);
    check("add_rd", {59'b0, out_rd}, 64'd5);
    check("add_store", out_store_data, 64'h1234);
    check("add_memw", {63'b0, out_mem_write}, 64'd1);
    check("add_flags", {60'b0, flags_nzvc}, 64'b1001);

    // sub to zero: N=0 Z=1 C=1 V=0
    drive(1'b1, 64'h0, 3'b011, 1'b1, 1'b1, 1'b1);
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    check("sub_zero_now", {63'b0, zero_now}, 64'd1);
    tick();
    check("sub_flags", {60'b0, flags_nzvc}, 64'b0110);
    check("sub_memr", {63'b0, out_mem_read}, 64'd1);

    // back-pressure: A held while B waits
    drive(1'b1, 64'hA, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_a_loaded", out_result, 64'hA);
    out_ready = 1'b0;
    drive(1'b1, 64'hB, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      tick();
      check("bp_hold_result", out_result, 64'hA);
      check("bp_hold_valid", {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {63'b0, in_ready}, 64'd1);
    tick();
    check("bp_b_result", out_result, 64'hB);
    check("bp_b_valid", {63'b0, out_valid}, 64'd1);
    check("bp_flags_kept", {60'b0, flags_nzvc}, 64'b0110);

    // drain with nothing behind it: payload holds
    drive(1'b0, 64'hC, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    check("drain_valid", {63'b0, out_valid}, 64'd0);
    check("drain_result", out_result, 64'hB);

    // reserved op with set_flags: payload captured, flags untouched
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b1, 1'b0, 1'b1);
    tick();
    check("rsv_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rsv_flags", {60'b0, flags_nzvc}, 64'b0110);
    drive(1'b1, 64'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    tick();
    check("rsv7_flags", {60'b0, flags_nzvc}, 64'b0110);

    // back to 1001, then flush with a flag-setting op presented
    drive(1'b1, 64'h8000_0000_0000_0000, 3'b010, 1'b0, 1'b1, 1'b1);
    tick();
    check("re_add_flags", {60'b0, flags_nzvc}, 64'b1001);
    flush = 1'b1;
    drive(1'b1, 64'h0, 3'b010, 1'b1, 1'b1, 1'b1);
    #1;
    check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_flags", {60'b0, flags_nzvc}, 64'b1001);
    check("flush_result", out_result, 64'h8000_0000_0000_0000);
    flush = 1'b0;

    // AND with zero result: bypass timing
    drive(1'b1, 64'h0, 3'b100, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef FLAG_BYPASS_EN
    check("and_flags_same_cycle", {60'b0, flags_nzvc}, 64'b0100);
`else
    check("and_flags_same_cycle", {60'b0, flags_nzvc}, 64'b1001);
`endif
    tick();
    check("and_flags_next", {60'b0, flags_nzvc}, 64'b0100);

    // XOR clears C/V even with carries asserted
    drive(1'b1, 64'h8000_0000_0000_0001, 3'b110, 1'b1, 1'b0, 1'b1);
    tick();
    check("xor_flags", {60'b0, flags_nzvc}, 64'b1000);

    // set_flags low on arithmetic: flags retained
    drive(1'b1, 64'h0, 3'b011, 1'b1, 1'b0, 1'b0);
    tick();
    check("nosf_flags", {60'b0, flags_nzvc}, 64'b1000);
    check("nosf_result", out_result, 64'h0);

    // asynchronous reset mid-cycle with a valid entry held
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {63'b0, out_valid}, 64'd0);
    check("arst_flags", {60'b0, flags_nzvc}, 64'd0);
    check("arst_rd", {59'b0, out_rd}, 64'd0);
    check("arst_regw", {63'b0, out_reg_write}, 64'd0);
    check("arst_memr", {63'b0, out_mem_read}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 64'h55, 3'b101, 1'b0, 1'b0, 1'b1);
    tick();
    check("post_rst_valid", {63'b0, out_valid}, 64'd1);
    check("post_rst_result", out_result, 64'h55);
    check("post_rst_flags", {60'b0, flags_nzvc}, 64'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
